// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with flush; head is presented combinationally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          push_ok, pop_ok;

    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: credit-limited prefetch, in-order response queue,
// redirect with stale-response dropping, and a registered decode interface.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INSN = fetch_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stop,
    input  logic            bubble,
    input  logic            wb_pc,
    input  logic [XLEN-1:0] wb_pc_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] command,
    output logic            command_valid,
    output logic [XLEN-1:0] now_pc
);
    localparam int CW = $clog2(DEPTH+1);
    // Stale responses can pile up across back-to-back redirects, so give headroom.
    localparam int DW = CW + 4;

    logic [CW-1:0]   q_count, outstanding;
    logic [DW-1:0]   drop_cnt;
    logic            q_full, q_empty, pc_full, pc_empty;
    logic            fire, rsp_live, q_pop;
    logic [XLEN-1:0] pc_head;
    fetch_entry_t    q_in, q_head;

    assign mem_req_valid = !reset && !stop && !wb_pc && !pc_full && !q_full &&
                           ((CW+1)'(q_count) + (CW+1)'(outstanding) < (CW+1)'(DEPTH));
    assign fire     = mem_req_valid && mem_req_ready;
    assign rsp_live = mem_rsp_valid && (drop_cnt == '0) && !wb_pc && !pc_empty;
    assign q_pop    = !wb_pc && !stop && !bubble && !q_empty;
    assign q_in     = '{pc: pc_head, insn: mem_rsp_data};

    // Side FIFO of issued addresses; its occupancy is the live outstanding count.
    fetch_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_pc_fifo (
        .clk(clk), .reset(reset), .flush(wb_pc),
        .push(fire), .push_data(mem_addr), .pop(rsp_live),
        .head_data(pc_head), .full(pc_full), .empty(pc_empty), .count(outstanding)
    );

    fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_queue (
        .clk(clk), .reset(reset), .flush(wb_pc),
        .push(rsp_live), .push_data(q_in), .pop(q_pop),
        .head_data(q_head), .full(q_full), .empty(q_empty), .count(q_count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            mem_addr <= RESET_PC;
        else if (wb_pc)
            mem_addr <= wb_pc_data;
        else if (fire)
            mem_addr <= mem_addr + XLEN'(4);
    end

    // On redirect every live request turns stale; a response landing that edge consumes one.
    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= '0;
        else if (wb_pc)
            drop_cnt <= drop_cnt + DW'(outstanding) - DW'(mem_rsp_valid);
        else if (mem_rsp_valid && drop_cnt != '0)
            drop_cnt <= drop_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            command       <= NOP_INSN;
            command_valid <= 1'b0;
            now_pc        <= RESET_PC;
        end else if (wb_pc) begin
            command       <= NOP_INSN;
            command_valid <= 1'b0;
        end else if (!stop) begin
            if (q_pop) begin
                command       <= q_head.insn;
                command_valid <= 1'b1;
                now_pc        <= q_head.pc;
            end else begin
                command       <= NOP_INSN;
                command_valid <= 1'b0;
            end
        end
    end
endmodule
